// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
package mul_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int MUL_WIDTH = 32;

    // Iteration counter must hold WIDTH itself, hence the extra bit.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A, then an
// arithmetic right shift of the {A,Q,q_m1} chain by one bit.
module booth_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   a_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             qm1_i,
    input  logic [WIDTH:0]   m_i,
    output logic [WIDTH:0]   a_o,
    output logic [WIDTH-1:0] q_o,
    output logic             qm1_o
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = a_i;
        unique case ({q_i[0], qm1_i})
            2'b01:   sum = a_i + m_i;
            2'b10:   sum = a_i - m_i;
            default: sum = a_i;
        endcase
    end

    assign {a_o, q_o, qm1_o} = {sum[WIDTH], sum, q_i};

endmodule

// File: rtl/booth_mul.sv
// Sequential radix-2 Booth signed multiplier, one step per clock.
// Optional overflow flag built when BOOTH_MUL_OVF_EN is defined.
module booth_mul
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   x_in,
    input  logic [WIDTH-1:0]   y_in,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
`ifdef BOOTH_MUL_OVF_EN
    ,
    output logic               ovf
`endif
);

    localparam int CW = cnt_width(WIDTH);

    state_t             state_q;
    logic [WIDTH:0]     m_q, a_q, a_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               qm1_q, qm1_d;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .a_i  (a_q),
        .q_i  (q_q),
        .qm1_i(qm1_q),
        .m_i  (m_q),
        .a_o  (a_d),
        .q_o  (q_d),
        .qm1_o(qm1_d)
    );

    // Bit WIDTH of A only guards the add/sub and never reaches the product.
    assign prod_d = {a_d[WIDTH-1:0], q_d};

`ifdef BOOTH_MUL_OVF_EN
    logic ovf_q, ovf_d;
    assign ovf_d = ~((&prod_d[2*WIDTH-1:WIDTH-1]) | ~(|prod_d[2*WIDTH-1:WIDTH-1]));
    assign ovf   = ovf_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
`ifdef BOOTH_MUL_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: if (start) begin
                    m_q     <= {x_in[WIDTH-1], x_in};
                    a_q     <= '0;
                    q_q     <= y_in;
                    qm1_q   <= 1'b0;
                    cnt_q   <= CW'(WIDTH);
                    state_q <= CALC;
                end
                CALC: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    qm1_q <= qm1_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        prod_q  <= prod_d;
`ifdef BOOTH_MUL_OVF_EN
                        ovf_q   <= ovf_d;
`endif
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready   = (state_q == IDLE);
    assign busy    = (state_q == CALC);
    assign done    = (state_q == DONE);
    assign product = prod_q;

endmodule

// File: tb/tb_booth_mul.sv
// Self-checking bench for booth_mul (WIDTH=32); ovf checks when BOOTH_MUL_OVF_EN.
module tb_booth_mul;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  x_in = '0, y_in = '0;
    logic          ready, busy, done;
    logic [2*W-1:0] product;
`ifdef BOOTH_MUL_OVF_EN
    logic          ovf;
`endif

    int n_chk = 0;
    int n_fail = 0;

    booth_mul #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst_n),
        .start  (start),
        .x_in   (x_in),
        .y_in   (y_in),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .product(product)
`ifdef BOOTH_MUL_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   x;
        logic [W-1:0]   y;
        logic [2*W-1:0] p;
        logic           o;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain signed arithmetic on 64-bit integers.
    function automatic logic [63:0] model_p(input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        return 64'(sx * sy);
    endfunction

    function automatic logic model_o(input logic [63:0] p);
        longint v;
        v = $signed(p);
        return (v > 64'sd2147483647) || (v < -64'sd2147483648);
    endfunction

    // Accept one operation; return product at the done cycle and the
    // number of edges from the accept edge to the first done sample.
    task automatic do_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [63:0] p, output int n);
        @(negedge clk);
        x_in = x; y_in = y; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        x_in = $urandom; y_in = $urandom;
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        p = product;
    endtask

    initial begin
        logic [63:0] p;
        int n, dones, m;
        logic [63:0] hold;

        tbl.push_back('{32'd3,        32'd5,        64'h0000_0000_0000_000F, 1'b0});
        tbl.push_back('{-32'sd7,      32'd6,        64'hFFFF_FFFF_FFFF_FFD6, 1'b0});
        tbl.push_back('{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1});
        tbl.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0});
        tbl.push_back('{32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 1'b1});
        tbl.push_back('{32'd1,        32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
        tbl.push_back('{32'd0,        32'h8000_0000, 64'h0,                  1'b0});
        tbl.push_back('{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b1});
        tbl.push_back('{-32'sd4,      32'd4,        64'hFFFF_FFFF_FFFF_FFF0, 1'b0});

        // Reset state
        #12;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < tbl.size(); i++) begin
            do_mul(tbl[i].x, tbl[i].y, p, n);
            chk($sformatf("tbl%0d_latency", i), 64'(n), 64'(W));
            chk($sformatf("tbl%0d_product", i), p, tbl[i].p);
`ifdef BOOTH_MUL_OVF_EN
            chk($sformatf("tbl%0d_ovf", i), 64'(ovf), 64'(tbl[i].o));
`endif
        end

        // Product holds in IDLE with start low
        repeat (3) @(negedge clk);
        chk("hold_ready", 64'(ready), 64'd1);
        chk("hold_product", product, tbl[tbl.size()-1].p);

        // Busy through the run, then a single done pulse
        @(negedge clk);
        x_in = 32'd2; y_in = 32'd2; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        dones = 0; m = 0; hold = '0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 10) begin start = 1'b1; x_in = 32'd9; y_in = 32'd9; end
            if (e == 11) start = 1'b0;
            if (e < W && busy) m++;
            if (done) begin dones++; hold = product; end
        end
        chk("ign_busy_cycles", 64'(m), 64'(W - 1));
        chk("ign_done_count", 64'(dones), 64'd1);
        chk("ign_product", hold, 64'd4);

        // Asynchronous reset mid-CALC
        do_mul(32'd7, 32'd7, p, n);
        @(negedge clk);
        x_in = 32'd100; y_in = 32'd100; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", 64'(ready), 64'd1);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_product", product, 64'd0);
        dones = 0;
        repeat (3) begin @(negedge clk); if (done) dones++; end
        rst_n = 1'b1;
        repeat (W + 4) begin @(negedge clk); if (done) dones++; end
        chk("arst_no_done", 64'(dones), 64'd0);
        do_mul(32'd4, 32'd4, p, n);
        chk("arst_after_latency", 64'(n), 64'(W));
        chk("arst_after_product", p, 64'd16);

        // Random operands against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] rx, ry;
            rx = $urandom;
            ry = $urandom;
            if (i % 3 == 0) begin rx = rx >>> 16; ry = ry >>> 18; end
            do_mul(rx, ry, p, n);
            chk($sformatf("rnd%0d_product", i), p, model_p(rx, ry));
`ifdef BOOTH_MUL_OVF_EN
            chk($sformatf("rnd%0d_ovf", i), 64'(ovf), 64'(model_o(model_p(rx, ry))));
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
